// File: rtl/order_issue_queue_mw.sv
// In-order issue queue: circular FIFO between dispatch and one in-order execution pipe.
// Multi-lane dispatch with lane compaction, writeback wakeup with same-cycle bypass,
// and prefix issue strictly from the head. DEPTH need not be a power of two.
module order_issue_queue_mw #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DISP_WIDTH  = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned WB_WIDTH    = 4,
  parameter int unsigned PREG_W      = 6,
  parameter int unsigned PAYLOAD_W   = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush_i,
  input  logic [DISP_WIDTH-1:0]                    disp_valid_i,
  output logic                                     disp_ready_o,
  input  logic [DISP_WIDTH-1:0][1:0][PREG_W-1:0]   disp_psrc_i,
  input  logic [DISP_WIDTH-1:0][1:0]               disp_psrc_valid_i,
  input  logic [DISP_WIDTH-1:0][1:0]               disp_psrc_ready_i,
  input  logic [DISP_WIDTH-1:0][PAYLOAD_W-1:0]     disp_payload_i,
  input  logic [WB_WIDTH-1:0]                      wb_valid_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]          wb_pdest_i,
  output logic [ISSUE_WIDTH-1:0]                   issue_valid_o,
  input  logic [ISSUE_WIDTH-1:0]                   issue_ready_i,
  output logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]    issue_payload_o,
  output logic [ISSUE_WIDTH-1:0][1:0][PREG_W-1:0]  issue_psrc_o,
  output logic [$clog2(DEPTH+1)-1:0]               count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [DEPTH-1:0]                   r_valid;
  logic [DEPTH-1:0][1:0]              r_rdy;
  logic [DEPTH-1:0][1:0][PREG_W-1:0]  r_psrc;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]    r_payload;
  logic [PTR_W-1:0]                   r_head;
  logic [PTR_W-1:0]                   r_tail;
  logic [CNT_W-1:0]                   r_count;

  logic                               w_disp_ready;
  logic                               w_disp_fire;
  logic [CNT_W-1:0]                   w_n_disp;
  logic [DISP_WIDTH-1:0][PTR_W-1:0]   w_lane_idx;
  logic [PTR_W-1:0]                   w_tail_nxt;
  logic [ISSUE_WIDTH-1:0][PTR_W-1:0]  w_iss_idx;
  logic [ISSUE_WIDTH-1:0]             w_iss_valid;
  logic [CNT_W-1:0]                   w_pop;
  logic [PTR_W-1:0]                   w_head_nxt;

  // Pointer advance modulo DEPTH by explicit compare (inc never exceeds DEPTH).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p) + SUM_W'(inc);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return PTR_W'(s);
  endfunction

  // True when any writeback port broadcasts this tag.
  function automatic logic wb_hit(input logic [PREG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (wb_valid_i[j] && (wb_pdest_i[j] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Dispatch acceptance and compaction of valid lanes onto tail, tail+1, ...
  always_comb begin
    logic [CNT_W-1:0] ofs;
    ofs          = '0;
    w_lane_idx   = '0;
    w_disp_ready = (r_count <= CNT_W'(DEPTH - DISP_WIDTH));
    for (int l = 0; l < DISP_WIDTH; l++) begin
      w_lane_idx[l] = ptr_add(r_tail, ofs);
      if (disp_valid_i[l]) ofs = ofs + CNT_W'(1);
    end
    w_n_disp    = ofs;
    w_disp_fire = w_disp_ready && (ofs != '0);
    w_tail_nxt  = ptr_add(r_tail, ofs);
  end

  // Prefix issue select from the head and leading-handshake pop count.
  always_comb begin
    logic             run;
    logic [CNT_W-1:0] pop;
    run         = 1'b1;
    pop         = '0;
    w_iss_idx   = '0;
    w_iss_valid = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_iss_idx[k]   = ptr_add(r_head, CNT_W'(k));
      w_iss_valid[k] = run && (CNT_W'(k) < r_count) && r_valid[w_iss_idx[k]] &&
                       (&r_rdy[w_iss_idx[k]]);
      run            = w_iss_valid[k];
    end
    run = 1'b1;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (run && w_iss_valid[k] && issue_ready_i[k]) pop = pop + CNT_W'(1);
      else run = 1'b0;
    end
    w_pop      = pop;
    w_head_nxt = ptr_add(r_head, pop);
  end

  // Issue lane data is the head window of the storage.
  always_comb begin
    issue_payload_o = '0;
    issue_psrc_o    = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      issue_payload_o[k] = r_payload[w_iss_idx[k]];
      issue_psrc_o[k]    = r_psrc[w_iss_idx[k]];
    end
  end

  assign disp_ready_o  = w_disp_ready;
  assign issue_valid_o = w_iss_valid;
  assign count_o       = r_count;

  // Control state: pointers, occupancy, valid and ready bits; flush beats everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_rdy   <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_rdy   <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int s = 0; s < 2; s++) begin
          if (r_valid[e] && wb_hit(r_psrc[e][s])) r_rdy[e][s] <= 1'b1;
        end
      end
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (CNT_W'(k) < w_pop) r_valid[w_iss_idx[k]] <= 1'b0;
      end
      if (w_disp_fire) begin
        for (int l = 0; l < DISP_WIDTH; l++) begin
          if (disp_valid_i[l]) begin
            r_valid[w_lane_idx[l]] <= 1'b1;
            for (int s = 0; s < 2; s++) begin
              r_rdy[w_lane_idx[l]][s] <= disp_psrc_ready_i[l][s] | ~disp_psrc_valid_i[l][s] |
                                         wb_hit(disp_psrc_i[l][s]);
            end
          end
        end
        r_tail <= w_tail_nxt;
      end
      r_head  <= w_head_nxt;
      r_count <= r_count + (w_disp_fire ? w_n_disp : CNT_W'(0)) - w_pop;
    end
  end

  // Entry tags and payload; contents of free slots are don't-care.
  always_ff @(posedge clk) begin
    if (w_disp_fire) begin
      for (int l = 0; l < DISP_WIDTH; l++) begin
        if (disp_valid_i[l]) begin
          r_psrc[w_lane_idx[l]]    <= disp_psrc_i[l];
          r_payload[w_lane_idx[l]] <= disp_payload_i[l];
        end
      end
    end
  end

  // Structural invariants.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CNT_W'(DEPTH));
  a_issue_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    (w_iss_valid & ISSUE_WIDTH'(w_iss_valid + ISSUE_WIDTH'(1))) == '0);
  a_pop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    w_pop <= r_count);

endmodule

// File: tb/tb_order_issue_queue_mw.sv
// Bench for order_issue_queue_mw: queue-level reference model plus payload scoreboard,
// directed scenarios followed by random traffic, and a DEPTH=6 ordering/wrap run.
module tb_order_issue_queue_mw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;

  // DEPTH=8 instance
  logic [1:0]             disp_valid;
  logic                   disp_ready;
  logic [1:0][1:0][5:0]   disp_psrc;
  logic [1:0][1:0]        psrc_valid;
  logic [1:0][1:0]        psrc_ready;
  logic [1:0][63:0]       disp_payload;
  logic [3:0]             wb_valid;
  logic [3:0][5:0]        wb_pdest;
  logic [1:0]             issue_valid;
  logic [1:0]             issue_ready;
  logic [1:0][63:0]       issue_payload;
  logic [1:0][1:0][5:0]   issue_psrc;
  logic [3:0]             count;

  // DEPTH=6 instance
  logic                   d6_flush;
  logic [1:0]             d6_disp_valid;
  logic                   d6_disp_ready;
  logic [1:0][1:0][5:0]   d6_disp_psrc;
  logic [1:0][1:0]        d6_psrc_valid;
  logic [1:0][1:0]        d6_psrc_ready;
  logic [1:0][63:0]       d6_disp_payload;
  logic [3:0]             d6_wb_valid;
  logic [3:0][5:0]        d6_wb_pdest;
  logic [1:0]             d6_issue_valid;
  logic [1:0]             d6_issue_ready;
  logic [1:0][63:0]       d6_issue_payload;
  logic [1:0][1:0][5:0]   d6_issue_psrc;
  logic [2:0]             d6_count;

  order_issue_queue_mw #(.DEPTH(8), .DISP_WIDTH(2), .ISSUE_WIDTH(2), .WB_WIDTH(4),
                         .PREG_W(6), .PAYLOAD_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_psrc_i(disp_psrc),
    .disp_psrc_valid_i(psrc_valid), .disp_psrc_ready_i(psrc_ready),
    .disp_payload_i(disp_payload), .wb_valid_i(wb_valid), .wb_pdest_i(wb_pdest),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
    .issue_payload_o(issue_payload), .issue_psrc_o(issue_psrc), .count_o(count)
  );

  order_issue_queue_mw #(.DEPTH(6), .DISP_WIDTH(2), .ISSUE_WIDTH(2), .WB_WIDTH(4),
                         .PREG_W(6), .PAYLOAD_W(64)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush_i(d6_flush),
    .disp_valid_i(d6_disp_valid), .disp_ready_o(d6_disp_ready), .disp_psrc_i(d6_disp_psrc),
    .disp_psrc_valid_i(d6_psrc_valid), .disp_psrc_ready_i(d6_psrc_ready),
    .disp_payload_i(d6_disp_payload), .wb_valid_i(d6_wb_valid), .wb_pdest_i(d6_wb_pdest),
    .issue_valid_o(d6_issue_valid), .issue_ready_i(d6_issue_ready),
    .issue_payload_o(d6_issue_payload), .issue_psrc_o(d6_issue_psrc), .count_o(d6_count)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model for the DEPTH=8 queue ----------------
  typedef struct {
    logic [63:0] pl;
    logic [5:0]  t0;
    logic [5:0]  t1;
    bit          r0;
    bit          r1;
  } ment_t;

  ment_t       mq[$];
  logic [63:0] sbq[$];

  function automatic bit wb_match(input logic [5:0] t);
    for (int j = 0; j < 4; j++) if (wb_valid[j] && wb_pdest[j] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int          n;
    int          p;
    bit          run;
    logic [1:0]  ev;
    logic [63:0] epl;
    ment_t       e;
    n   = mq.size();
    ev  = '0;
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (run && k < n && mq[k].r0 && mq[k].r1) ev[k] = 1'b1;
      else run = 1'b0;
    end
    chk("issue_valid", 64'(issue_valid), 64'(ev));
    chk("count", 64'(count), 64'(n));
    chk("disp_ready", 64'(disp_ready), 64'((8 - n) >= 2));
    // scoreboard: every accepted issue lane must carry the next dispatched payload
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (run && issue_valid[k] && issue_ready[k]) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: lane %0d issued %0h with nothing expected", k,
                   issue_payload[k]);
        end else begin
          epl = sbq.pop_front();
          chk("issue_payload", issue_payload[k], epl);
          if (k < n) chk("issue_psrc", 64'(issue_psrc[k]), 64'({mq[k].t1, mq[k].t0}));
        end
      end else run = 1'b0;
    end
    p = 0;
    for (int k = 0; k < 2; k++) begin
      if (ev[k] && issue_ready[k] && p == k) p++;
    end
    if (flush) begin
      mq.delete();
      sbq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (wb_match(e.t0)) e.r0 = 1'b1;
        if (wb_match(e.t1)) e.r1 = 1'b1;
        mq[i] = e;
      end
      repeat (p) void'(mq.pop_front());
      if ((8 - n) >= 2 && disp_valid != 2'b00) begin
        for (int l = 0; l < 2; l++) begin
          if (disp_valid[l]) begin
            e.pl = disp_payload[l];
            e.t0 = disp_psrc[l][0];
            e.t1 = disp_psrc[l][1];
            e.r0 = psrc_ready[l][0] || !psrc_valid[l][0] || wb_match(disp_psrc[l][0]);
            e.r1 = psrc_ready[l][1] || !psrc_valid[l][1] || wb_match(disp_psrc[l][1]);
            mq.push_back(e);
            sbq.push_back(e.pl);
          end
        end
      end
    end
  endtask

  // Monitor for the DEPTH=8 queue, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) model_step();
    else begin
      mq.delete();
      sbq.delete();
    end
  end

  // ---------------- model for the DEPTH=6 queue (all sources ready) ----------------
  int m6_cnt = 0;
  int m6_out = 0;

  always @(negedge clk) begin
    int         n;
    int         p;
    bit         run;
    logic [1:0] ev;
    if (!rst_n) begin
      m6_cnt = 0;
      m6_out = 0;
    end else begin
      n  = m6_cnt;
      ev = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      chk("d6_issue_valid", 64'(d6_issue_valid), 64'(ev));
      chk("d6_count", 64'(d6_count), 64'(n));
      chk("d6_disp_ready", 64'(d6_disp_ready), 64'((6 - n) >= 2));
      run = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (run && d6_issue_valid[k] && d6_issue_ready[k]) begin
          chk("d6_order", d6_issue_payload[k], 64'(m6_out));
          m6_out++;
        end else run = 1'b0;
      end
      p = 0;
      for (int k = 0; k < 2; k++) if (ev[k] && d6_issue_ready[k] && p == k) p++;
      m6_cnt = n - p;
      if ((6 - n) >= 2) m6_cnt = m6_cnt + $countones(d6_disp_valid);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    disp_valid   = '0;
    disp_psrc    = '0;
    psrc_valid   = '0;
    psrc_ready   = '0;
    disp_payload = '0;
    wb_valid     = '0;
    wb_pdest     = '0;
    issue_ready  = '0;
    flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp2(input logic [1:0] v, input logic [63:0] pl0);
    disp_valid   = v;
    psrc_valid   = '1;
    psrc_ready   = '1;
    disp_psrc[0] = {6'd2, 6'd1};
    disp_psrc[1] = {6'd4, 6'd3};
    disp_payload = {pl0 + 64'd1, pl0};
  endtask

  initial begin
    int          nxt;
    int          j;
    logic [1:0]  pat;
    rst_n = 1'b0;
    idle();
    d6_flush        = 1'b0;
    d6_disp_valid   = '0;
    d6_disp_psrc    = '0;
    d6_psrc_valid   = '0;
    d6_psrc_ready   = '0;
    d6_disp_payload = '0;
    d6_wb_valid     = '0;
    d6_wb_pdest     = '0;
    d6_issue_ready  = '0;
    #12;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    rst_n = 1'b1;
    step();

    // fill 2 per cycle with consumer stalled
    for (int i = 0; i < 4; i++) begin
      disp2(2'b11, 64'(100 + 2 * i));
      step();
      chk("fill_count", 64'(count), 64'(2 * (i + 1)));
    end
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    step();
    chk("full_ignored", 64'(count), 64'd8);

    // drain 2 per cycle
    idle();
    issue_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(issue_valid), 64'd3);
      step();
      chk("drain_count", 64'(count), 64'(6 - 2 * i));
    end

    // head blocked on tag 7 holds back a ready younger entry
    idle();
    disp_valid      = 2'b11;
    psrc_valid[0]   = 2'b01;
    disp_psrc[0][0] = 6'd7;
    disp_payload    = {64'd201, 64'd200};
    issue_ready     = 2'b11;
    step();
    idle();
    issue_ready = 2'b11;
    chk("blocked_head", 64'(issue_valid), 64'd0);
    step();
    wb_valid    = 4'b0100;
    wb_pdest[2] = 6'd7;
    chk("blocked_at_wb", 64'(issue_valid), 64'd0);
    step();
    wb_valid = '0;
    chk("woken", 64'(issue_valid), 64'd3);
    step();
    chk("woken_drained", 64'(count), 64'd0);

    // same-cycle writeback bypass into a dispatching entry
    idle();
    disp_valid      = 2'b01;
    psrc_valid[0]   = 2'b10;
    disp_psrc[0][1] = 6'd9;
    disp_payload[0] = 64'd300;
    wb_valid        = 4'b0001;
    wb_pdest[0]     = 6'd9;
    issue_ready     = 2'b11;
    step();
    idle();
    issue_ready = 2'b11;
    chk("bypass", 64'(issue_valid), 64'd1);
    step();
    chk("bypass_drained", 64'(count), 64'd0);

    // partial handshakes
    idle();
    disp2(2'b11, 64'd400);
    step();
    idle();
    chk("partial_pre", 64'(issue_valid), 64'd3);
    issue_ready = 2'b10;
    step();
    chk("partial_10", 64'(count), 64'd2);
    issue_ready = 2'b01;
    step();
    chk("partial_01", 64'(count), 64'd1);
    issue_ready = 2'b11;
    step();
    chk("partial_drained", 64'(count), 64'd0);

    // simultaneous dispatch and issue at count 6, then flush
    idle();
    for (int i = 0; i < 3; i++) begin
      disp2(2'b11, 64'(500 + 2 * i));
      step();
    end
    chk("simul_pre", 64'(count), 64'd6);
    disp2(2'b11, 64'd520);
    issue_ready = 2'b11;
    step();
    chk("simul_count", 64'(count), 64'd6);
    disp2(2'b11, 64'd530);
    issue_ready = 2'b11;
    flush       = 1'b1;
    step();
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(issue_valid), 64'd0);

    // asynchronous reset in mid-cycle
    disp2(2'b11, 64'd600);
    step();
    step();
    idle();
    chk("pre_async_count", 64'(count), 64'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_ready", 64'(disp_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    step();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      disp_valid = 2'($urandom_range(0, 3));
      for (int l = 0; l < 2; l++) begin
        for (int s = 0; s < 2; s++) begin
          disp_psrc[l][s]  = 6'($urandom_range(0, 15));
          psrc_valid[l][s] = 1'($urandom_range(0, 1));
          psrc_ready[l][s] = ($urandom_range(0, 3) == 0);
        end
        disp_payload[l] = {32'($urandom), 32'($urandom)};
      end
      for (int w = 0; w < 4; w++) begin
        wb_valid[w] = ($urandom_range(0, 2) == 0);
        wb_pdest[w] = 6'($urandom_range(0, 15));
      end
      issue_ready = 2'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 49) == 0);
      step();
    end
    idle();
    flush = 1'b1;
    step();
    idle();

    // DEPTH=6: payloads 0..19 must come out in order across pointer wrap
    nxt = 0;
    for (int c = 0; c < 300 && m6_out < 20; c++) begin
      d6_issue_ready = 2'($urandom_range(0, 3));
      d6_disp_valid  = '0;
      if (nxt < 20) begin
        pat = 2'($urandom_range(1, 3));
        if (nxt == 19 && pat == 2'b11) pat = 2'b10;
        j = nxt;
        for (int l = 0; l < 2; l++) begin
          d6_disp_payload[l] = 64'(j);
          if (pat[l]) j++;
        end
        if (pat == 2'b10) d6_disp_payload[1] = 64'(nxt);
        d6_disp_valid = pat;
        if ((6 - m6_cnt) >= 2) nxt = j;
      end
      step();
    end
    d6_disp_valid  = '0;
    d6_issue_ready = 2'b11;
    step();
    chk("d6_all_issued", 64'(m6_out), 64'd20);
    chk("d6_empty", 64'(d6_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
